// File: rtl/demux_sequencial.sv
// Sequential 1-to-2 demux: a debounced button release swaps which
// registered output bus follows dataIn.
module demux_sequencial #(
  parameter int DATABUS_WIDTH   = 9,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     toggleButton,
  input  logic [DATABUS_WIDTH-1:0] dataIn,
  output logic [DATABUS_WIDTH-1:0] dataOut1,
  output logic [DATABUS_WIDTH-1:0] dataOut2,
  output logic                     focus,
  output logic                     togglePulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    FOCUS1 = 1'b0,
    FOCUS2 = 1'b1
  } focus_e;

  logic                     sync0_q, sync0_d;
  logic                     sync1_q, sync1_d;
  logic                     btn_db_q, btn_db_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  focus_e                   state_q, state_d;
  logic                     pulse_q, pulse_d;
  logic [DATABUS_WIDTH-1:0] out1_q, out1_d;
  logic [DATABUS_WIDTH-1:0] out2_q, out2_d;
  logic                     cnt_full;
  logic                     release_s;

  assign cnt_full = (cnt_q == CNT_MAX);

  // Release is recognised on the very edge btn_db falls, so the
  // focus flip lines up with the debounced level change.
  assign release_s = btn_db_q & ~sync1_q & cnt_full;

  always_comb begin
    sync0_d  = toggleButton;
    sync1_d  = sync0_q;
    btn_db_d = btn_db_q;
    cnt_d    = '0;
    if (sync1_q != btn_db_q) begin
      if (cnt_full) begin
        btn_db_d = sync1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    state_d = state_q;
    unique case (state_q)
      FOCUS1: if (release_s) state_d = FOCUS2;
      FOCUS2: if (release_s) state_d = FOCUS1;
      default: state_d = FOCUS1;
    endcase

    pulse_d = release_s;

    out1_d = out1_q;
    out2_d = out2_q;
    if (state_q == FOCUS1) begin
      out1_d = dataIn;
    end else begin
      out2_d = dataIn;
    end

    if (rst) begin
      sync0_d  = 1'b0;
      sync1_d  = 1'b0;
      btn_db_d = 1'b0;
      cnt_d    = '0;
      state_d  = FOCUS1;
      pulse_d  = 1'b0;
      out1_d   = '0;
      out2_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    sync0_q  <= sync0_d;
    sync1_q  <= sync1_d;
    btn_db_q <= btn_db_d;
    cnt_q    <= cnt_d;
    state_q  <= state_d;
    pulse_q  <= pulse_d;
    out1_q   <= out1_d;
    out2_q   <= out2_d;
  end

  assign dataOut1    = out1_q;
  assign dataOut2    = out2_q;
  assign focus       = state_q;
  assign togglePulse = pulse_q;

endmodule

// File: doc/demux_sequencial.md
Name: demux_sequencial

Overview:
- Sequential 1-to-2 demultiplexer: routes one shared data bus to one of two registered output buses.
- The active destination toggles on each debounced release of a push-button.
- Sits between a single data source and two downstream consumers.
- Contains its own button synchronizer and debouncer, so the raw board button connects directly.

Parameters:
- DATABUS_WIDTH, 9, width of dataIn, dataOut1 and dataOut2.
- DEBOUNCE_CYCLES, 16, consecutive stable clk cycles needed to accept a button level change (must be >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- toggleButton  input  1  raw asynchronous button, high = pressed.
- dataIn  input  DATABUS_WIDTH  shared source data.
- dataOut1  output  DATABUS_WIDTH  destination 1, registered.
- dataOut2  output  DATABUS_WIDTH  destination 2, registered.
- focus  output  1  current destination: 0 = FOCUS1 (dataOut1), 1 = FOCUS2 (dataOut2).
- togglePulse  output  1  one-cycle strobe, high in the cycle after focus changes.

Behaviour:
- Reset (rst high at a rising edge):
  - focus=FOCUS1, dataOut1=0, dataOut2=0, togglePulse=0.
  - Synchronizer flops=0, debounced level btn_db=0, debounce counter=0.
  - Reset mid-debounce discards the pending count; no toggle is produced.
- Synchronizer: 2-flop chain on toggleButton; btn_sync is the second flop.
- Debouncer:
  - Each edge with btn_sync==btn_db: counter cleared.
  - Each edge with btn_sync!=btn_db: if counter==DEBOUNCE_CYCLES-1, btn_db<=btn_sync and counter<=0; else counter increments.
  - Any bounce back to btn_db before the threshold restarts the count.
- Focus state machine, two states:
  - FOCUS1 -> FOCUS2 and FOCUS2 -> FOCUS1 on the edge where btn_db transitions 1->0 (debounced release).
  - Debounced press (0->1) causes no transition.
  - No other transitions.
- Release latency: with the first edge that samples raw toggleButton low counted as edge 1, focus flips on edge DEBOUNCE_CYCLES+2.
  - This assumes the raw input stays low throughout and btn_db was 1.
- togglePulse: registered, equals 1 exactly one cycle after each focus flip, else 0.
- Data path, on every edge not in reset, based on the focus value before the edge:
  - focus=FOCUS1: dataOut1<=dataIn; dataOut2 holds.
  - focus=FOCUS2: dataOut2<=dataIn; dataOut1 holds.
  - Latency dataIn -> selected output is 1 cycle.
  - On the edge where focus flips, the old destination captures dataIn one last time; the new destination starts capturing on the following edge.
- The unselected output holds the last value it captured indefinitely; it is never cleared except by reset.
- Button held pressed through reset deassertion:
  - btn_db rises after debounce.
  - Only the subsequent release toggles.
- Press and release shorter than DEBOUNCE_CYCLES cycles are ignored entirely.

Test Plan:
- Reset check (DEBOUNCE_CYCLES=4): rst high 3 cycles, dataIn=9'h1AA -> during reset dataOut1=0, dataOut2=0, focus=0, togglePulse=0.
- Basic routing: after rst low, dataIn=9'h055 -> dataOut1=9'h055 one cycle later, dataOut2 stays 0.
- Toggle with exact timing (DEBOUNCE_CYCLES=4):
  - Stimulus: hold button high 10 cycles, then drop it low.
  - Required: focus=1 after the 6th edge sampling low; togglePulse high for exactly one cycle after that.
  - Then dataIn=9'h0F0 -> dataOut2=9'h0F0 and dataOut1 frozen at its last value.
- Bounce rejection: button high 10 cycles, then low 2 cycles, high 1, low 2, high 10 -> no focus change, togglePulse never asserted.
- Second toggle wraps: two valid press/release sequences -> focus goes 0->1->0; dataOut2 retains the value from its focus period.
- Reset mid-debounce:
  - Stimulus: release button; assert rst on the 3rd edge after release; deassert.
  - Required: focus stays 0, no togglePulse, counter restarts from 0.
